buffer_rolhas_param: RTL and testbench

BUFFER_ROLHAS_PARAM -- requirements
Module: buffer_rolhas_param

---
 rtl/buffer_rolhas_param_pkg.sv | 19 +
 rtl/contador_updown_param.sv | 28 ++
 rtl/buffer_rolhas_param.sv | 167 ++++++++++++++++
 tb/tb_buffer_rolhas_param.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/buffer_rolhas_param_pkg.sv
// Shared types and default sizing for the cork buffer block.
// Imported by the buffer top and its counter.
package buffer_rolhas_param_pkg;

    localparam int DEF_W_SEC   = 7;
    localparam int DEF_CAP_SEC = 99;
    localparam int DEF_W_PRI   = 5;
    localparam int DEF_CAP_PRI = 20;
    localparam int DEF_LOTE    = 15;
    localparam int DEF_MIN_PRI = 5;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_LOAD     = 2'b01,
        ST_TRANSFER = 2'b10,
        ST_RSVD     = 2'b11
    } estado_t;

endpackage

// File: rtl/contador_updown_param.sv
// Saturating up/down counter with parallel load, clamped to [0, cap].
// inc and dec together cancel out.
module contador_updown_param #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    input  logic         dec,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    input  logic [W-1:0] cap,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            count <= '0;
        end else if (ld) begin
            count <= (ld_val > cap) ? cap : ld_val;
        end else if (inc && !dec && count < cap) begin
            count <= count + 1'b1;
        end else if (dec && !inc && count != '0) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/buffer_rolhas_param.sv
// Two-level cork buffer: operator loads the secondary store, which
// refills the primary store in fixed batches while sealing consumes it.
module buffer_rolhas_param
    import buffer_rolhas_param_pkg::*;
#(
    parameter int W_SEC   = DEF_W_SEC,
    parameter int CAP_SEC = DEF_CAP_SEC,
    parameter int W_PRI   = DEF_W_PRI,
    parameter int CAP_PRI = DEF_CAP_PRI,
    parameter int LOTE    = DEF_LOTE,
    parameter int MIN_PRI = DEF_MIN_PRI
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             enable,
    input  logic             load_req,
    input  logic [W_SEC-1:0] load_qty,
    output logic             load_ack,
    output logic             load_nack,
    input  logic             consume,
    output logic [W_PRI-1:0] pri_count,
    output logic [W_SEC-1:0] sec_count,
    output logic             ro,
    output logic             low_pri,
    output logic             busy,
    output logic [1:0]       estado
);

    localparam logic [W_SEC:0]   CAP_SEC_X = (W_SEC+1)'(CAP_SEC);
    localparam logic [W_SEC-1:0] CAP_SEC_N = W_SEC'(CAP_SEC);
    localparam logic [W_SEC-1:0] LOTE_S    = W_SEC'(LOTE);
    localparam logic [W_PRI:0]   LOTE_P    = (W_PRI+1)'(LOTE);
    localparam logic [W_PRI:0]   CAP_PRI_X = (W_PRI+1)'(CAP_PRI);
    localparam logic [W_PRI-1:0] CAP_PRI_N = W_PRI'(CAP_PRI);
    localparam logic [W_PRI-1:0] MIN_P     = W_PRI'(MIN_PRI);
    localparam logic [W_PRI-1:0] LAST_STEP = W_PRI'(LOTE - 1);

    estado_t          state_q, state_d;
    logic [W_PRI-1:0] xfer_q, xfer_d;
    logic [W_SEC-1:0] qty_q, qty_d;
    logic             req_low_q, req_low_d;
    logic             ack_q, ack_d;
    logic             nack_q, nack_d;

    logic [W_SEC:0]   sec_sum;
    logic [W_PRI:0]   pri_sum;
    logic             qty_ok;
    logic             req_new;
    logic             xfer_ok;
    logic             step;
    logic             use_cork;
    logic             sec_ld;
    logic [W_SEC-1:0] sec_ld_val;

    assign sec_sum  = {1'b0, sec_count} + {1'b0, load_qty};
    assign pri_sum  = {1'b0, pri_count} + LOTE_P;
    assign qty_ok   = (load_qty != '0) && (sec_sum <= CAP_SEC_X);
    // A held request only counts once it has been seen low in between
    assign req_new  = load_req && req_low_q;
    assign xfer_ok  = !req_new && low_pri
                   && (sec_count >= LOTE_S)
                   && (pri_sum <= CAP_PRI_X);

    assign step       = enable && (state_q == ST_TRANSFER);
    assign use_cork   = enable && consume;
    assign sec_ld_val = sec_count + qty_q;

    always_comb begin
        state_d   = state_q;
        xfer_d    = xfer_q;
        qty_d     = qty_q;
        req_low_d = req_low_q;
        ack_d     = 1'b0;
        nack_d    = 1'b0;
        sec_ld    = 1'b0;
        if (enable) begin
            if (!load_req) begin
                req_low_d = 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (req_new) begin
                        req_low_d = 1'b0;
                        if (qty_ok) begin
                            state_d = ST_LOAD;
                            qty_d   = load_qty;
                        end else begin
                            nack_d  = 1'b1;
                        end
                    end else if (xfer_ok) begin
                        state_d = ST_TRANSFER;
                        xfer_d  = '0;
                    end
                end
                ST_LOAD: begin
                    sec_ld  = 1'b1;
                    ack_d   = 1'b1;
                    state_d = ST_IDLE;
                end
                ST_TRANSFER: begin
                    if (xfer_q == LAST_STEP) begin
                        state_d = ST_IDLE;
                        xfer_d  = '0;
                    end else begin
                        xfer_d  = xfer_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q == ST_RSVD) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= ST_IDLE;
            xfer_q    <= '0;
            qty_q     <= '0;
            req_low_q <= 1'b1;
            ack_q     <= 1'b0;
            nack_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            xfer_q    <= xfer_d;
            qty_q     <= qty_d;
            req_low_q <= req_low_d;
            ack_q     <= ack_d;
            nack_q    <= nack_d;
        end
    end

    // A transfer step plus a consumed cork leaves the primary count unchanged
    contador_updown_param #(
        .W(W_PRI)
    ) u_pri (
        .clk    (clk),
        .clr    (clr),
        .inc    (step),
        .dec    (use_cork),
        .ld     (1'b0),
        .ld_val ('0),
        .cap    (CAP_PRI_N),
        .count  (pri_count)
    );

    contador_updown_param #(
        .W(W_SEC)
    ) u_sec (
        .clk    (clk),
        .clr    (clr),
        .inc    (1'b0),
        .dec    (step),
        .ld     (sec_ld),
        .ld_val (sec_ld_val),
        .cap    (CAP_SEC_N),
        .count  (sec_count)
    );

    assign load_ack  = ack_q & enable;
    assign load_nack = nack_q & enable;
    assign ro        = (pri_count == '0);
    assign low_pri   = (pri_count < MIN_P);
    assign busy      = (state_q == ST_TRANSFER);
    assign estado    = state_q;

endmodule

// File: tb/tb_buffer_rolhas_param.sv
// Scoreboard bench for the cork buffer: load responses and transfer
// completions are queued by stimulus and checked by a monitor.
module tb_buffer_rolhas_param;

    localparam int W_SEC = 7;
    localparam int W_PRI = 5;

    logic             clk = 1'b0;
    logic             clr = 1'b0;
    logic             enable = 1'b0;
    logic             load_req = 1'b0;
    logic [W_SEC-1:0] load_qty = '0;
    logic             consume = 1'b0;
    logic             load_ack, load_nack, ro, low_pri, busy;
    logic [W_PRI-1:0] pri_count;
    logic [W_SEC-1:0] sec_count;
    logic [1:0]       estado;

    int n_err = 0;
    int n_chk = 0;
    int cyc = 0;
    int mon_busy = 0;
    bit mon_prev = 1'b0;

    typedef struct {
        int kind;
        int sec;
        int cyc;
        int ro;
    } resp_t;

    typedef struct {
        int pri;
        int sec;
        int cycles;
    } xfer_t;

    resp_t resp_q[$];
    xfer_t xfer_q[$];

    buffer_rolhas_param #(
        .W_SEC(7), .CAP_SEC(99), .W_PRI(5),
        .CAP_PRI(20), .LOTE(15), .MIN_PRI(5)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .enable    (enable),
        .load_req  (load_req),
        .load_qty  (load_qty),
        .load_ack  (load_ack),
        .load_nack (load_nack),
        .consume   (consume),
        .pri_count (pri_count),
        .sec_count (sec_count),
        .ro        (ro),
        .low_pri   (low_pri),
        .busy      (busy),
        .estado    (estado)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin : monitor
        resp_t r;
        xfer_t x;
        forever begin
            @(negedge clk);
            if (load_ack || load_nack) begin
                if (resp_q.size() == 0) begin
                    chk("unexpected_resp", 1, 0);
                end else begin
                    r = resp_q.pop_front();
                    chk("resp_kind", int'(load_ack), r.kind);
                    chk("resp_sec", int'(sec_count), r.sec);
                    if (r.cyc >= 0) chk("resp_cycle", cyc, r.cyc);
                    if (r.ro >= 0) chk("resp_ro", int'(ro), r.ro);
                end
            end
            if (busy) begin
                mon_busy++;
            end else if (mon_prev) begin
                if (xfer_q.size() == 0) begin
                    chk("unexpected_xfer", 1, 0);
                end else begin
                    x = xfer_q.pop_front();
                    chk("xfer_pri", int'(pri_count), x.pri);
                    chk("xfer_sec", int'(sec_count), x.sec);
                    chk("xfer_cycles", mon_busy, x.cycles);
                end
                mon_busy = 0;
            end
            mon_prev = busy;
        end
    end

    task automatic do_load(input int qty, input int kind, input int sec,
                           input int lat, input int ro_e, input int hold);
        resp_t r;
        bit got;
        @(posedge clk);
        #1;
        load_req = 1'b1;
        load_qty = W_SEC'(qty);
        r.kind = kind;
        r.sec  = sec;
        r.cyc  = (lat < 0) ? -1 : cyc + lat;
        r.ro   = ro_e;
        resp_q.push_back(r);
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (load_ack || load_nack) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("load_timeout", 0, 1);
        repeat (hold) @(negedge clk);
        load_req = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic wait_xfer(output int mn, output int mx);
        bit seen;
        bit done;
        seen = 1'b0;
        done = 1'b0;
        mn = 1000;
        mx = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy) begin
                seen = 1'b1;
                if (int'(pri_count) < mn) mn = int'(pri_count);
                if (int'(pri_count) > mx) mx = int'(pri_count);
            end else if (seen) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk("xfer_timeout", 0, 1);
    endtask

    task automatic wait_busy();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("busy_timeout", 0, 1);
    endtask

    initial begin : stim
        int mn, mx;
        enable = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_pri", int'(pri_count), 0);
        chk("rst_sec", int'(sec_count), 0);
        chk("rst_ro", int'(ro), 1);
        chk("rst_low", int'(low_pri), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_estado", int'(estado), 0);
        chk("rst_ack", int'(load_ack), 0);
        chk("rst_nack", int'(load_nack), 0);
        @(posedge clk);
        #1 clr = 1'b1;

        @(posedge clk);
        #1 consume = 1'b1;
        repeat (3) @(posedge clk);
        #1 consume = 1'b0;
        chk("empty_pri", int'(pri_count), 0);
        chk("empty_ro", int'(ro), 1);

        xfer_q.push_back('{15, 25, 15});
        do_load(40, 1, 40, 2, 1, 0);
        wait_xfer(mn, mx);
        chk("low_after_xfer", int'(low_pri), 0);

        do_load(65, 1, 90, 2, -1, 5);
        do_load(10, 0, 90, 1, -1, 0);
        do_load(0, 0, 90, 1, -1, 0);
        do_load(9, 1, 99, 2, -1, 0);
        do_load(1, 0, 99, 1, -1, 0);

        xfer_q.push_back('{3, 84, 15});
        xfer_q.push_back('{18, 69, 15});
        #1 consume = 1'b1;
        wait_xfer(mn, mx);
        consume = 1'b0;
        chk("frozen_span", mx - mn, 0);
        chk("frozen_pri", mn, 3);
        wait_xfer(mn, mx);

        xfer_q.push_back('{19, 54, 19});
        @(posedge clk);
        #1 consume = 1'b1;
        repeat (14) @(posedge clk);
        #1 consume = 1'b0;
        wait_busy();
        repeat (7) @(posedge clk);
        #1 enable = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("pause_pri", int'(pri_count), 11);
        chk("pause_sec", int'(sec_count), 62);
        chk("pause_busy", int'(busy), 1);
        enable = 1'b1;
        wait_xfer(mn, mx);

        xfer_q.push_back('{0, 0, 5});
        @(posedge clk);
        #1 consume = 1'b1;
        repeat (15) @(posedge clk);
        #1 consume = 1'b0;
        wait_busy();
        repeat (5) @(posedge clk);
        #1 clr = 1'b0;
        #1;
        chk("abort_pri", int'(pri_count), 0);
        chk("abort_sec", int'(sec_count), 0);
        chk("abort_estado", int'(estado), 0);
        chk("abort_busy", int'(busy), 0);
        repeat (2) @(posedge clk);
        #1 clr = 1'b1;

        xfer_q.push_back('{15, 5, 15});
        do_load(20, 1, 20, 2, -1, 0);
        #1;
        chk("busy_at_req", int'(busy), 1);
        do_load(5, 1, 10, -1, -1, 0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("end_pri", int'(pri_count), 15);
        chk("end_sec", int'(sec_count), 10);
        chk("resp_left", resp_q.size(), 0);
        chk("xfer_left", xfer_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
